// File: rtl/io_avalon_bridge_pkg.sv
// Shared types for the uncached I/O to Avalon-MM bridge: word/pointer types,
// the bridge FSM state encoding and the read data returned on an aborted read.
package io_avalon_bridge_pkg;

    typedef logic [29:0] ptr;
    typedef logic [31:0] word;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        RDWAIT = 2'd2,
        DONE   = 2'd3
    } io_bridge_state_t;

    localparam word IO_ERR_RDATA       = 32'hDEADC0DE;
    localparam int  IO_TIMEOUT_DEFAULT = 1024;

    // Word pointer to Avalon byte address.
    function automatic word byte_addr(input ptr p);
        return {p, 2'b00};
    endfunction

endpackage

// File: rtl/io_avalon_bridge_if.sv
// Core-side I/O port and Avalon-MM master bus, each with master/slave modports.
// Core side: io_start is a one-cycle request accepted only while the bridge is idle; io_ready is a
// one-cycle completion pulse and io_data_rd is meaningful only in that cycle. Avalon side: a
// command is held stable until a cycle with avl_waitrequest=0, read data arrives on
// avl_readdatavalid in that same cycle or any later one.
interface io_core_if;
    import io_avalon_bridge_pkg::*;

    logic io_start;
    logic io_write;
    ptr   io_addr;
    word  io_data_wr;
    logic io_ready;
    word  io_data_rd;
    logic bus_error;

    modport master (
        output io_start, io_write, io_addr, io_data_wr,
        input  io_ready, io_data_rd, bus_error
    );

    modport slave (
        input  io_start, io_write, io_addr, io_data_wr,
        output io_ready, io_data_rd, bus_error
    );
endinterface

interface avl_if;
    import io_avalon_bridge_pkg::*;

    word        avl_address;
    logic       avl_read;
    logic       avl_write;
    word        avl_writedata;
    logic [3:0] avl_byteenable;
    logic       avl_waitrequest;
    word        avl_readdata;
    logic       avl_readdatavalid;

    modport master (
        output avl_address, avl_read, avl_write, avl_writedata, avl_byteenable,
        input  avl_waitrequest, avl_readdata, avl_readdatavalid
    );

    modport slave (
        input  avl_address, avl_read, avl_write, avl_writedata, avl_byteenable,
        output avl_waitrequest, avl_readdata, avl_readdatavalid
    );
endinterface

// File: rtl/io_avalon_bridge.sv
// Turns each single-word core I/O request into one Avalon-MM transfer, with a bounded
// timeout so a dead slave still returns io_ready to the core.
module io_avalon_bridge
    import io_avalon_bridge_pkg::*;
#(
    parameter int  TIMEOUT_CYCLES = IO_TIMEOUT_DEFAULT,
    parameter word ERR_RDATA      = IO_ERR_RDATA
) (
    input  logic             clk,
    input  logic             rst,
    io_core_if.slave         core,
    avl_if.master            avl,
    output io_bridge_state_t state_dbg_o
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    io_bridge_state_t state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic             rd_q, rd_d;
    logic             wr_q, wr_d;
    logic             is_write_q, is_write_d;
    ptr               addr_q, addr_d;
    word              wdata_q, wdata_d;
    word              rdata_q, rdata_d;
    logic             err_q, err_d;

    logic accept;
    logic timeout_hit;
    logic [TW-1:0] timer_inc;

    assign accept      = (rd_q | wr_q) & ~avl.avl_waitrequest;
    assign timeout_hit = (timer_q == TW'(TIMEOUT_CYCLES - 1));
    assign timer_inc   = (timer_q == {TW{1'b1}}) ? timer_q : timer_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            is_write_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            is_write_q <= is_write_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        is_write_d = is_write_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        err_d      = err_q;

        unique case (state_q)
            IDLE: begin
                // Stray readdatavalid here belongs to an aborted read and is dropped.
                if (core.io_start) begin
                    addr_d     = core.io_addr;
                    wdata_d    = core.io_data_wr;
                    is_write_d = core.io_write;
                    rd_d       = ~core.io_write;
                    wr_d       = core.io_write;
                    timer_d    = '0;
                    state_d    = ISSUE;
                end
            end

            ISSUE: begin
                timer_d = timer_inc;
                // Completing in the timeout cycle itself takes priority over the abort.
                if (accept && (is_write_q || avl.avl_readdatavalid)) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    if (!is_write_q) begin
                        rdata_d = avl.avl_readdata;
                    end
                    state_d = DONE;
                end else if (timeout_hit) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    err_d   = 1'b1;
                    if (!is_write_q) begin
                        rdata_d = ERR_RDATA;
                    end
                    state_d = DONE;
                end else if (accept) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    state_d = RDWAIT;
                end
            end

            RDWAIT: begin
                timer_d = timer_inc;
                if (avl.avl_readdatavalid) begin
                    rdata_d = avl.avl_readdata;
                    state_d = DONE;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    rdata_d = ERR_RDATA;
                    state_d = DONE;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // A request while busy (including the DONE cycle) is dropped and flagged.
        if (core.io_start && (state_q != IDLE)) begin
            err_d = 1'b1;
        end
    end

    assign core.io_ready   = (state_q == DONE);
    assign core.io_data_rd = rdata_q;
    assign core.bus_error  = err_q;

    assign avl.avl_address    = byte_addr(addr_q);
    assign avl.avl_read       = rd_q;
    assign avl.avl_write      = wr_q;
    assign avl.avl_writedata  = wdata_q;
    assign avl.avl_byteenable = 4'b1111;

    assign state_dbg_o = state_q;

endmodule

// File: tb/tb_io_avalon_bridge.sv
// Bench for io_avalon_bridge: directed vector table, hand-written corner sequences and
// randomized transfers checked against a cycle-count reference model.
module tb_io_avalon_bridge;
  import io_avalon_bridge_pkg::*;

  localparam int T = 16;

  logic clk;
  logic rst;
  io_bridge_state_t state_dbg;

  io_core_if core_if ();
  avl_if     avl_bus ();

  io_avalon_bridge #(.TIMEOUT_CYCLES(T)) dut (
    .clk         (clk),
    .rst         (rst),
    .core        (core_if),
    .avl         (avl_bus),
    .state_dbg_o (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- reference model ----------------
  // The transfer finishes at the end of cycle c counted from the first command cycle;
  // anything not finished by the end of cycle T is aborted there.
  function automatic void model(input bit wr, input int ws, input int rdv, output int lat,
                                output int cmd, output bit to);
    int c;
    if (wr) c = ws + 1;
    else if (rdv < 0) c = 1 << 20;
    else c = ws + 1 + rdv;
    to  = (c > T);
    lat = to ? T + 1 : c + 1;
    cmd = (ws + 1 < T) ? ws + 1 : T;
  endfunction

  // ---------------- driver ----------------
  // lat counts cycles from the io_start cycle to the io_ready cycle (-1 if none).
  task automatic run_xfer(input bit wr, input logic [29:0] a, input logic [31:0] wd,
                          input int ws, input int rdv_dly, input logic [31:0] rd, input bit stray,
                          output int lat, output int cmd_cycles, output logic [31:0] got,
                          output bit bus_ok);
    int since_acc;
    bit acc;
    lat = -1; cmd_cycles = 0; got = '0; bus_ok = 1'b1; acc = 1'b0; since_acc = 0;
    @(negedge clk);
    core_if.io_start   = 1'b1;
    core_if.io_write   = wr;
    core_if.io_addr    = a;
    core_if.io_data_wr = wd;
    avl_bus.avl_waitrequest   = 1'b1;
    avl_bus.avl_readdatavalid = stray;
    avl_bus.avl_readdata      = stray ? 32'hBAD0BAD0 : 32'h0;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      @(negedge clk);
      core_if.io_start = 1'b0;
      avl_bus.avl_readdatavalid = 1'b0;
      if (core_if.io_ready) begin
        lat = cyc;
        got = core_if.io_data_rd;
        break;
      end
      if (acc) since_acc++;
      if (avl_bus.avl_read || avl_bus.avl_write) begin
        cmd_cycles++;
        if (avl_bus.avl_address != {a, 2'b00} || avl_bus.avl_write != wr ||
            avl_bus.avl_read != !wr || avl_bus.avl_byteenable != 4'hF ||
            (wr && avl_bus.avl_writedata != wd)) bus_ok = 1'b0;
        avl_bus.avl_waitrequest = (cmd_cycles <= ws);
        if (cmd_cycles > ws) begin
          acc = 1'b1;
          since_acc = 0;
        end
      end
      if (acc && !wr && rdv_dly >= 0 && since_acc == rdv_dly) begin
        avl_bus.avl_readdatavalid = 1'b1;
        avl_bus.avl_readdata      = rd;
      end
    end
    avl_bus.avl_waitrequest   = 1'b0;
    avl_bus.avl_readdatavalid = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit          wr;
    logic [29:0] addr;
    logic [31:0] wdata;
    int          ws;
    int          rdv;
    logic [31:0] rdata;
    int          exp_lat;
    int          exp_cmd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[6];

  int lat, cmd, exp_lat, exp_cmd;
  logic [31:0] got, exp_rd;
  bit ok, to, err_m;
  int readies, xfers;

  initial begin
    rst = 1'b0;
    core_if.io_start = 1'b0; core_if.io_write = 1'b0;
    core_if.io_addr = '0; core_if.io_data_wr = '0;
    avl_bus.avl_waitrequest = 1'b0; avl_bus.avl_readdata = '0; avl_bus.avl_readdatavalid = 1'b0;

    vecs[0] = '{1'b1, 30'h100, 32'hA5A50001, 0,  0, 32'h0,        2,  1,  32'h0};
    vecs[1] = '{1'b0, 30'h040, 32'h0,        3,  2, 32'h12345678, 7,  4,  32'h12345678};
    vecs[2] = '{1'b0, 30'h3FF, 32'h0,        0,  0, 32'h0BADF00D, 2,  1,  32'h0BADF00D};
    vecs[3] = '{1'b1, 30'h001, 32'h5A5A5A5A, 5,  0, 32'h0,        7,  6,  32'h0};
    vecs[4] = '{1'b0, 30'h222, 32'h0,        14, 1, 32'hFEEDBEEF, 17, 15, 32'hFEEDBEEF};
    vecs[5] = '{1'b1, 30'h333, 32'h77777777, 15, 0, 32'h0,        17, 16, 32'h0};

    do_reset();
    #1;
    check("rst_avl_read",  {31'h0, avl_bus.avl_read},  32'h0);
    check("rst_avl_write", {31'h0, avl_bus.avl_write}, 32'h0);
    check("rst_io_ready",  {31'h0, core_if.io_ready},  32'h0);
    check("rst_io_data_rd", core_if.io_data_rd,        32'h0);
    check("rst_bus_error", {31'h0, core_if.bus_error}, 32'h0);
    check("rst_state",     32'(state_dbg),             32'(IDLE));

    for (int i = 0; i < 6; i++) begin
      run_xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].ws, vecs[i].rdv,
               vecs[i].rdata, 1'b0, lat, cmd, got, ok);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("vec%0d_cmd_cycles", i), 32'(cmd), 32'(vecs[i].exp_cmd));
      check($sformatf("vec%0d_bus_fields", i), {31'h0, ok}, 32'h1);
      if (!vecs[i].wr) check($sformatf("vec%0d_rdata", i), got, vecs[i].exp_rd);
      check($sformatf("vec%0d_bus_error", i), {31'h0, core_if.bus_error}, 32'h0);
    end

    // Read whose slave never answers: forced completion with error data.
    run_xfer(1'b0, 30'h02A, 32'h0, 0, -1, 32'h0, 1'b0, lat, cmd, got, ok);
    check("to_latency",   32'(lat), 32'(T + 1));
    check("to_rdata",     got, IO_ERR_RDATA);
    check("to_bus_error", {31'h0, core_if.bus_error}, 32'h1);
    @(negedge clk);
    avl_bus.avl_readdatavalid = 1'b1;
    avl_bus.avl_readdata      = 32'h11111111;
    readies = 0;
    repeat (3) begin
      @(negedge clk);
      avl_bus.avl_readdatavalid = 1'b0;
      if (core_if.io_ready) readies++;
    end
    check("late_rdv_no_ready", 32'(readies), 32'h0);
    check("late_rdv_data",     core_if.io_data_rd, IO_ERR_RDATA);
    check("late_rdv_state",    32'(state_dbg), 32'(IDLE));
    check("sticky_bus_error",  {31'h0, core_if.bus_error}, 32'h1);
    run_xfer(1'b0, 30'h055, 32'h0, 1, 1, 32'hCAFEF00D, 1'b1, lat, cmd, got, ok);
    check("post_to_latency", 32'(lat), 32'h4);
    check("post_to_rdata",   got, 32'hCAFEF00D);

    // Overlapping request one cycle after the first.
    do_reset();
    @(negedge clk);
    core_if.io_start = 1'b1; core_if.io_write = 1'b1;
    core_if.io_addr = 30'h010; core_if.io_data_wr = 32'h01010101;
    @(negedge clk);
    core_if.io_addr = 30'h020; core_if.io_data_wr = 32'h02020202;
    avl_bus.avl_waitrequest = 1'b0;
    readies = 0; xfers = 0; ok = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (avl_bus.avl_write || avl_bus.avl_read) begin
        xfers++;
        if (avl_bus.avl_address != 32'h40) ok = 1'b0;
      end
      if (core_if.io_ready) readies++;
      @(negedge clk);
      core_if.io_start = 1'b0;
    end
    check("ovl_transfers", 32'(xfers), 32'h1);
    check("ovl_readies",   32'(readies), 32'h1);
    check("ovl_addr",      {31'h0, ok}, 32'h1);
    check("ovl_bus_error", {31'h0, core_if.bus_error}, 32'h1);

    // Reset asserted while waiting for read data.
    @(negedge clk);
    core_if.io_start = 1'b1; core_if.io_write = 1'b0; core_if.io_addr = 30'h077;
    avl_bus.avl_waitrequest = 1'b1;
    @(negedge clk);
    core_if.io_start = 1'b0;
    avl_bus.avl_waitrequest = 1'b0;
    @(negedge clk);
    check("rdwait_state", 32'(state_dbg), 32'(RDWAIT));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_avl_read", {31'h0, avl_bus.avl_read}, 32'h0);
    check("mid_rst_io_ready", {31'h0, core_if.io_ready}, 32'h0);
    check("mid_rst_bus_error", {31'h0, core_if.bus_error}, 32'h0);
    check("mid_rst_state", 32'(state_dbg), 32'(IDLE));
    avl_bus.avl_readdatavalid = 1'b1;
    avl_bus.avl_readdata      = 32'h55555555;
    @(negedge clk);
    avl_bus.avl_readdatavalid = 1'b0;
    check("mid_rst_discard_ready", {31'h0, core_if.io_ready}, 32'h0);
    check("mid_rst_discard_data",  core_if.io_data_rd, 32'h0);
    run_xfer(1'b0, 30'h078, 32'h0, 0, 1, 32'h87654321, 1'b0, lat, cmd, got, ok);
    check("after_rst_latency", 32'(lat), 32'h3);
    check("after_rst_rdata",   got, 32'h87654321);

    // Randomized transfers against the reference model.
    do_reset();
    err_m = 1'b0;
    for (int i = 0; i < 40; i++) begin
      bit wr;
      int ws, rdv;
      logic [29:0] a;
      logic [31:0] wd, rd;
      wr  = 1'($urandom_range(0, 1));
      ws  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(14, 18)) : int'($urandom_range(0, 4));
      rdv = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 3));
      a   = 30'($urandom);
      wd  = $urandom;
      rd  = $urandom;
      model(wr, ws, rdv, exp_lat, exp_cmd, to);
      err_m = err_m | to;
      if (!wr) exp_q.push_back(to ? IO_ERR_RDATA : rd);
      run_xfer(wr, a, wd, ws, rdv, rd, 1'($urandom_range(0, 1)), lat, cmd, got, ok);
      check($sformatf("rnd%0d_latency", i), 32'(lat), 32'(exp_lat));
      check($sformatf("rnd%0d_cmd_cycles", i), 32'(cmd), 32'(exp_cmd));
      check($sformatf("rnd%0d_bus_fields", i), {31'h0, ok}, 32'h1);
      if (!wr) begin
        exp_rd = exp_q.pop_front();
        check($sformatf("rnd%0d_rdata", i), got, exp_rd);
      end
      check($sformatf("rnd%0d_bus_error", i), {31'h0, core_if.bus_error}, {31'h0, err_m});
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
